// File: rtl/vga_refresh_scheduler.sv
// vga_refresh_scheduler
// ---------------------
// Purpose: once per frame, during vertical blanking, reads the nine RTC
// registers behind the on-screen date, time and chronometer fields and
// republishes each byte to the digit renderer. Because the digits only change
// while blanking, they never change mid-frame.
//
// Ports:
//   reloj        system clock, rising edge
//   resetM       synchronous active-low reset
//   V_ON         1 in the active vertical region, 0 in vertical blanking
//   bus_req      read request to the RTC bus controller
//   bus_addr     RTC register address, stable while bus_req is high
//   bus_ack      RTC controller: bus_dato is valid this cycle
//   bus_dato     RTC read data (BCD)
//   RD           one-cycle strobe: DIR_DATO is valid for field POSICION
//   POSICION     field index 0..8 (held between strobes)
//   DIR_DATO     field value, BCD, passed through unmodified (held between strobes)
//   frame_ok     the last sequence fetched every field without a timeout
//   err_timeout  at least one field timed out in the current/last sequence
module vga_refresh_scheduler #(
  parameter int N_CAMPOS = 9,
  parameter int TIMEOUT  = 63
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       V_ON,
  output logic       bus_req,
  output logic [7:0] bus_addr,
  input  logic       bus_ack,
  input  logic [7:0] bus_dato,
  output logic       RD,
  output logic [3:0] POSICION,
  output logic [7:0] DIR_DATO,
  output logic       frame_ok,
  output logic       err_timeout
);

  localparam int             CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]     LAST_IDX  = 4'(N_CAMPOS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    PUBLISH,
    NEXT
  } state_t;

  state_t           state;
  logic             v_q;
  logic             abort_q;
  logic [3:0]       idx;
  logic [CNT_W-1:0] wait_cnt;

  // RTC register address for each field: date, then time, then chronometer.
  function automatic logic [7:0] field_addr(input logic [3:0] i);
    case (i)
      4'd0:    field_addr = 8'h24;
      4'd1:    field_addr = 8'h25;
      4'd2:    field_addr = 8'h26;
      4'd3:    field_addr = 8'h23;
      4'd4:    field_addr = 8'h22;
      4'd5:    field_addr = 8'h21;
      4'd6:    field_addr = 8'h43;
      4'd7:    field_addr = 8'h42;
      4'd8:    field_addr = 8'h41;
      default: field_addr = 8'h00;
    endcase
  endfunction

  // Scan sequencer. All outputs are registered here.
  // The strobe is raised on the edge that sees the ack, so PUBLISH is the
  // cycle in which RD is visible; PUBLISH and NEXT (entered after a timeout)
  // then share the same end-of-field decision, keeping a field at three cycles.
  // The abort flag is only consulted at the end of a field so that an
  // in-flight handshake always completes.
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      state       <= IDLE;
      v_q         <= 1'b0;
      abort_q     <= 1'b0;
      idx         <= 4'd0;
      wait_cnt    <= '0;
      bus_req     <= 1'b0;
      bus_addr    <= 8'h00;
      RD          <= 1'b0;
      POSICION    <= 4'd0;
      DIR_DATO    <= 8'h00;
      frame_ok    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      v_q <= V_ON;
      RD  <= 1'b0;

      if (state != IDLE && V_ON) begin
        abort_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (v_q && !V_ON) begin
            state       <= REQ;
            idx         <= 4'd0;
            frame_ok    <= 1'b0;
            err_timeout <= 1'b0;
            abort_q     <= 1'b0;
          end
        end

        REQ: begin
          bus_req  <= 1'b1;
          bus_addr <= field_addr(idx);
          wait_cnt <= '0;
          state    <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            RD       <= 1'b1;
            POSICION <= idx;
            DIR_DATO <= bus_dato;
            state    <= PUBLISH;
          end else if (wait_cnt == TIMEOUT_C) begin
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        PUBLISH, NEXT: begin
          if (abort_q) begin
            state <= IDLE;
          end else if (idx == LAST_IDX) begin
            frame_ok <= ~err_timeout;
            state    <= IDLE;
          end else begin
            idx   <= idx + 4'd1;
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_refresh_scheduler.sv
// tb_vga_refresh_scheduler
// ------------------------
// Purpose: self-checking bench for vga_refresh_scheduler. A timeline model of
// the refresh sequence predicts every output each cycle; an RTC responder
// answers requests with configurable latency; directed scenarios add literal
// expectations on latencies, address order and published data.
module tb_vga_refresh_scheduler;

  localparam int N_CAMPOS = 9;
  localparam int TIMEOUT  = 63;

  logic       reloj = 1'b0;
  logic       resetM = 1'b0;
  logic       V_ON = 1'b1;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_dato = 8'h00;
  logic       RD;
  logic [3:0] POSICION;
  logic [7:0] DIR_DATO;
  logic       frame_ok;
  logic       err_timeout;

  vga_refresh_scheduler #(
    .N_CAMPOS(N_CAMPOS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .reloj      (reloj),
    .resetM     (resetM),
    .V_ON       (V_ON),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_dato   (bus_dato),
    .RD         (RD),
    .POSICION   (POSICION),
    .DIR_DATO   (DIR_DATO),
    .frame_ok   (frame_ok),
    .err_timeout(err_timeout)
  );

  always #5 reloj = ~reloj;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Responder policy
  logic ack_tied = 1'b1;
  int   ack_delay = 0;
  int   no_ack_addr = -1;

  // Event logs gathered by the compare process
  int   rd_pos[$];
  int   rd_dat[$];
  int   rise_cyc[$];
  int   rise_addr[$];
  int   len_log[$];
  int   hi_len = 0;
  int   addr_jumps = 0;
  logic prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  logic [7:0] exp_addr [9] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};

  // Model state
  logic       check_en = 1'b0;
  logic       m_req = 1'b0, m_rd = 1'b0, m_ok = 1'b0, m_err = 1'b0, m_vq = 1'b0;
  logic       m_active = 1'b0, m_abort = 1'b0, m_decide = 1'b0, m_rise = 1'b0;
  logic [7:0] m_addr = 8'h00, m_dat = 8'h00;
  logic [3:0] m_pos = 4'd0;
  int         m_idx = 0, m_wait = 0;

  // Field address from its position in the date/time/chrono groups.
  function automatic logic [7:0] field_address(input int i);
    if (i < 3)      return 8'(8'h24 + i);
    else if (i < 6) return 8'(8'h23 - (i - 3));
    else            return 8'(8'h43 - (i - 6));
  endfunction

  function automatic int addr_to_idx(input logic [7:0] a);
    for (int i = 0; i < N_CAMPOS; i++) begin
      if (field_address(i) == a) return i;
    end
    return 15;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rst, input int n);
    V_ON   = v;
    resetM = rst;
    repeat (n) begin
      @(posedge reloj);
      #2;
    end
  endtask

  task automatic clearLogs();
    rd_pos.delete();
    rd_dat.delete();
    rise_cyc.delete();
    rise_addr.delete();
    len_log.delete();
    addr_jumps = 0;
  endtask

  task automatic waitForRequest(input logic [7:0] addr, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus_req === 1'b1 && bus_addr === addr) found = 1;
      else applyStimulus(V_ON, resetM, 1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL wait_req: no request for addr 0x%0h within %0d cycles, expected one", addr, budget);
    end
  endtask

  // Timeline model: each rising edge, advance the refresh sequence by the
  // latency rules (request two edges after the falling V_ON, data strobe on
  // the edge after ack, end-of-field decision one edge later, next request
  // the edge after that).
  initial forever begin
    logic start, old_abort;
    @(posedge reloj);
    cyc++;
    if (!resetM) begin
      check_en = 1'b1;
      m_req = 0; m_rd = 0; m_ok = 0; m_err = 0; m_vq = 0;
      m_active = 0; m_abort = 0; m_decide = 0; m_rise = 0;
      m_addr = 0; m_dat = 0; m_pos = 0; m_idx = 0; m_wait = 0;
    end else begin
      start     = m_vq && !V_ON && !m_active;
      old_abort = m_abort;
      if (m_active && V_ON) m_abort = 1;
      m_vq = V_ON;
      m_rd = 0;
      if (start) begin
        m_active = 1; m_idx = 0; m_ok = 0; m_err = 0;
        m_abort = 0; m_rise = 1; m_decide = 0;
      end else if (m_active) begin
        if (m_req) begin
          if (bus_ack) begin
            m_req = 0; m_rd = 1; m_pos = 4'(m_idx); m_dat = bus_dato; m_decide = 1;
          end else if (m_wait == TIMEOUT) begin
            m_req = 0; m_err = 1; m_decide = 1;
          end else begin
            m_wait++;
          end
        end else if (m_decide) begin
          m_decide = 0;
          if (old_abort) begin
            m_active = 0;
          end else if (m_idx == N_CAMPOS - 1) begin
            m_ok = !m_err;
            m_active = 0;
          end else begin
            m_idx++;
            m_rise = 1;
          end
        end else if (m_rise) begin
          m_rise = 0; m_req = 1; m_addr = field_address(m_idx); m_wait = 0;
        end
      end
    end
  end

  // RTC responder: acks the request ack_delay cycles after it rises, except
  // for the address that is configured never to answer.
  initial begin
    int k = -1;
    forever begin
      @(posedge reloj);
      #2;
      if (bus_req === 1'b1) k++;
      else k = -1;
      bus_dato = 8'(8'h10 + addr_to_idx(bus_addr));
      if (ack_tied) bus_ack = 1'b1;
      else bus_ack = (bus_req === 1'b1) && (k == ack_delay) && (int'(bus_addr) != no_ack_addr);
    end
  end

  // Per-cycle compare against the model, plus event logging.
  initial forever begin
    logic [23:0] act, expv;
    @(negedge reloj);
    if (check_en) begin
      expv = {m_req, (m_req ? m_addr : 8'h00), m_rd, m_pos, m_dat, m_ok, m_err};
      act  = {bus_req, (bus_req ? bus_addr : 8'h00), RD, POSICION, DIR_DATO, frame_ok, err_timeout};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("[TB] FAIL cycle %0d outputs: got req=%b addr=%h rd=%b pos=%0d dato=%h ok=%b err=%b, expected req=%b addr=%h rd=%b pos=%0d dato=%h ok=%b err=%b",
                 cyc, act[23], act[22:15], act[14], act[13:10], act[9:2], act[1], act[0],
                 expv[23], expv[22:15], expv[14], expv[13:10], expv[9:2], expv[1], expv[0]);
      end
      if (RD === 1'b1) begin
        rd_pos.push_back(int'(POSICION));
        rd_dat.push_back(int'(DIR_DATO));
      end
      if (bus_req === 1'b1 && !prev_req) begin
        rise_cyc.push_back(cyc);
        rise_addr.push_back(int'(bus_addr));
        hi_len = 0;
      end
      if (bus_req === 1'b1) hi_len++;
      if (bus_req !== 1'b1 && prev_req) len_log.push_back(hi_len);
      if (bus_req === 1'b1 && prev_req && bus_addr !== prev_addr) addr_jumps++;
      prev_req  = (bus_req === 1'b1);
      prev_addr = bus_addr;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    @(posedge reloj);
    #2;

    // Reset held with V_ON toggling and ack tied high
    ack_tied = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'(i % 2), 1'b0, 1);
    checkOutput("reset bus_req", int'(bus_req), 0);
    checkOutput("reset RD", int'(RD), 0);
    checkOutput("reset POSICION", int'(POSICION), 0);
    checkOutput("reset DIR_DATO", int'(DIR_DATO), 0);
    checkOutput("reset frame_ok", int'(frame_ok), 0);
    checkOutput("reset err_timeout", int'(err_timeout), 0);
    checkOutput("reset no requests", rise_cyc.size(), 0);
    applyStimulus(1'b1, 1'b1, 3);

    // Zero-wait frame
    clearLogs();
    e = cyc;
    applyStimulus(1'b0, 1'b1, 40);
    checkOutput("zw first req latency", (rise_cyc.size() > 0) ? rise_cyc[0] - e : -1, 2);
    checkOutput("zw rd count", rd_pos.size(), 9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("zw rd pos", (i < rd_pos.size()) ? rd_pos[i] : -1, i);
      checkOutput("zw rd dato", (i < rd_dat.size()) ? rd_dat[i] : -1, 8'h10 + i);
      checkOutput("zw addr", (i < rise_addr.size()) ? rise_addr[i] : -1, int'(exp_addr[i]));
    end
    checkOutput("zw span", (rise_cyc.size() == 9) ? rise_cyc[8] - rise_cyc[0] : -1, 24);
    checkOutput("zw frame_ok", int'(frame_ok), 1);
    checkOutput("zw err_timeout", int'(err_timeout), 0);
    applyStimulus(1'b1, 1'b1, 3);

    // Wait states: ack five cycles after each request
    ack_tied = 1'b0;
    ack_delay = 5;
    no_ack_addr = -1;
    clearLogs();
    applyStimulus(1'b0, 1'b1, 85);
    checkOutput("ws req count", len_log.size(), 9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("ws req length", (i < len_log.size()) ? len_log[i] : -1, 6);
    end
    for (int i = 1; i < 9; i++) begin
      checkOutput("ws req spacing", (i < rise_cyc.size()) ? rise_cyc[i] - rise_cyc[i-1] : -1, 8);
    end
    checkOutput("ws addr stable", addr_jumps, 0);
    checkOutput("ws rd count", rd_pos.size(), 9);
    checkOutput("ws frame_ok", int'(frame_ok), 1);
    applyStimulus(1'b1, 1'b1, 3);

    // Abort: V_ON rises while field 3 waits for its ack
    ack_delay = 10;
    clearLogs();
    applyStimulus(1'b0, 1'b1, 1);
    waitForRequest(8'h23, 200);
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("abort rd count", rd_pos.size(), 4);
    checkOutput("abort last rd pos", (rd_pos.size() > 0) ? rd_pos[rd_pos.size()-1] : -1, 3);
    checkOutput("abort req count", rise_cyc.size(), 4);
    checkOutput("abort frame_ok", int'(frame_ok), 0);
    checkOutput("abort err_timeout", int'(err_timeout), 0);

    // Timeout: address 0x22 never answers
    ack_delay = 0;
    no_ack_addr = 8'h22;
    clearLogs();
    applyStimulus(1'b0, 1'b1, 110);
    checkOutput("to req length", (len_log.size() > 4) ? len_log[4] : -1, 64);
    checkOutput("to next req gap", (rise_cyc.size() > 5) ? rise_cyc[5] - rise_cyc[4] : -1, 66);
    checkOutput("to rd count", rd_pos.size(), 8);
    checkOutput("to rd skips 4", (rd_pos.size() > 4) ? rd_pos[4] : -1, 5);
    checkOutput("to err_timeout", int'(err_timeout), 1);
    checkOutput("to frame_ok", int'(frame_ok), 0);
    applyStimulus(1'b1, 1'b1, 3);

    // Reset during field 2's handshake, then a clean restart
    no_ack_addr = -1;
    ack_delay = 20;
    clearLogs();
    applyStimulus(1'b0, 1'b1, 1);
    waitForRequest(8'h26, 200);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("mr bus_req dropped", int'(bus_req), 0);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("mr no restart", int'(bus_req), 0);
    checkOutput("mr rd count", rd_pos.size(), 2);
    applyStimulus(1'b1, 1'b1, 3);
    clearLogs();
    applyStimulus(1'b0, 1'b1, 30);
    checkOutput("mr restart addr", (rise_addr.size() > 0) ? rise_addr[0] : -1, 8'h24);
    checkOutput("mr restart rd pos", (rd_pos.size() > 0) ? rd_pos[0] : -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
